// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state type and frame geometry.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_FRAME_BITS = 10;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO with extra-MSB pointers.
module byte_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [7:0]  mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop on the same edge frees the slot the write lands in, so full+pop still accepts.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/reg2_uart_tx.sv
// Queues every change of reg2 and serialises it as a UART 8N1 frame on tx.
module reg2_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] reg2,
  input  logic       enable,
  output logic       tx,
  output logic       busy,
  output logic       overflow
);

  localparam int unsigned BW = $clog2(CLKS_PER_BIT);

  logic [7:0]    reg2_q;
  logic          want_push;
  logic          fifo_push;
  logic          fifo_pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;

  uart_state_t   state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_d;
  logic          busy_d;
  logic          baud_end;

  assign want_push = (reg2 != reg2_q) && enable;
  assign fifo_push = want_push && (!fifo_full || fifo_pop);
  assign baud_end  = (baud_q == BW'(CLKS_PER_BIT - 1));

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .din     (reg2),
    .pop     (fifo_pop),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg2_q   <= '0;
      overflow <= 1'b0;
    end else begin
      reg2_q <= reg2;
      if (want_push && fifo_full && !fifo_pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx      <= tx_d;
      busy    <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx;
    fifo_pop = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          tx_d     = 1'b0;
          baud_d   = '0;
          state_d  = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'(UART_DATA_BITS - 1)) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            // Shift right so the next bit to send is always at shift_q[0].
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            tx_d     = 1'b0;
            state_d  = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Values pushed on this edge are not counted, so busy rises one edge after the first push.
    busy_d = (state_d != IDLE) || (!fifo_empty && !fifo_pop);
  end

endmodule

// File: tb/tb_reg2_uart_tx.sv
// Randomised bench: a timeline model of queued frames predicts tx, busy and overflow.
module tb_reg2_uart_tx;
  import uart_pkg::*;

  localparam int unsigned CPB   = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned FRAME = UART_FRAME_BITS * CPB;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] reg2 = 8'h00;
  logic       enable = 1'b1;
  logic       tx;
  logic       busy;
  logic       overflow;

  int unsigned checks = 0;
  int unsigned failures = 0;

  // Model state: pending values, value on the line, cycles left in the current frame.
  logic [7:0]  m_q[$];
  logic [7:0]  m_prev = 8'h00;
  logic [7:0]  m_cur = 8'h00;
  int unsigned m_rem = 0;
  int unsigned m_pend = 0;
  logic        m_ovf = 1'b0;

  reg2_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .reg2     (reg2),
    .enable   (enable),
    .tx       (tx),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic exp_tx();
    int unsigned idx;
    if (m_rem == 0) return 1'b1;
    idx = (FRAME - m_rem) / CPB;
    if (idx == 0) return 1'b0;
    if (idx == UART_FRAME_BITS - 1) return 1'b1;
    return m_cur[idx-1];
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_q.delete();
        m_prev = 8'h00;
        m_rem  = 0;
        m_pend = 0;
        m_ovf  = 1'b0;
      end else begin
        logic pop_now;
        pop_now = (m_rem <= 1) && (m_q.size() > 0);
        if (pop_now) m_cur = m_q.pop_front();
        m_pend = m_q.size();
        if (reg2 != m_prev && enable) begin
          if (m_q.size() < DEPTH) m_q.push_back(reg2);
          else m_ovf = 1'b1;
        end
        m_prev = reg2;
        if (pop_now) m_rem = FRAME;
        else if (m_rem > 0) m_rem--;
      end
    end
  end

  always @(negedge clk) begin
    chk("tx", {7'd0, tx}, {7'd0, exp_tx()});
    chk("busy", {7'd0, busy}, {7'd0, (m_rem > 0) || (m_pend > 0)});
    chk("overflow", {7'd0, overflow}, {7'd0, m_ovf});
  end

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
  endtask

  initial begin
    tick(2);
    reset_n = 1'b1;
    tick(1);

    // Zero held with enable: line must stay idle.
    reg2 = 8'h00;
    enable = 1'b1;
    tick(1000);

    // Single frame of 0xA5.
    reg2 = 8'hA5;
    tick(200);

    // Four consecutive changes, back-to-back frames.
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      reg2 = 8'(i);
      tick(1);
    end
    tick(4 * FRAME + 20);
    chk("burst4_ovf", {7'd0, overflow}, 8'd0);

    // Six distinct consecutive changes: last one dropped.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      reg2 = 8'h10 + 8'(i);
      tick(1);
    end
    chk("burst6_ovf", {7'd0, overflow}, 8'd1);
    tick(5 * FRAME + 20);
    chk("burst6_ovf_sticky", {7'd0, overflow}, 8'd1);

    // Change while disabled is not sent later.
    do_reset();
    enable = 1'b0;
    reg2 = 8'h3C;
    tick(3);
    enable = 1'b1;
    tick(FRAME);

    // Reset mid-DATA of 0xFF with a second value queued.
    reg2 = 8'h00;
    do_reset();
    reg2 = 8'hFF;
    tick(1);
    reg2 = 8'h11;
    tick(5 * CPB);
    reset_n = 1'b0;
    #1;
    chk("tx_async_reset", {7'd0, tx}, 8'd1);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    tick(2 * FRAME);
    reg2 = 8'h00;
    tick(2);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(FRAME);

    // Random changes, enables and bursts.
    do_reset();
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 99) < 4) begin
        int unsigned len;
        len = $urandom_range(1, 7);
        for (int j = 0; j < int'(len); j++) begin
          reg2 = 8'($urandom);
          enable = ($urandom_range(0, 9) != 0);
          tick(1);
        end
      end else begin
        if ($urandom_range(0, 99) < 2) enable = ~enable;
        tick(1);
      end
    end
    enable = 1'b1;
    tick(8 * FRAME);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
